crc_stream_engine: RTL and testbench

//  Parametrised streaming CRC generator/checker for the UART/Avalon datapath; covers any CRC-1..64
//  (Rocksoft model: POLY/INIT/REFIN/REFOUT/XOROUT), DATA_W bits per beat, frame-delimited input.

---
 rtl/crc_stream_engine.sv | 145 ++++++++++++++
 tb/tb_crc_stream_engine.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: streaming Rocksoft-model CRC (1..64 bit) generator/checker over framed DATA_W-bit beats.
// Latency: one beat per cycle (fully unrolled); result register valid one cycle after the eop beat is accepted.
// Backpressure: s_ready drops only while a result is held and m_ready is low; clear flushes everything.
module crc_stream_engine #(
    parameter int unsigned      CRC_W   = 8,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(8'h31),
    parameter logic [CRC_W-1:0] INIT    = {CRC_W{1'b1}},
    parameter int unsigned      DATA_W  = 8,
    parameter bit               REFIN   = 1'b0,
    parameter bit               REFOUT  = 1'b0,
    parameter logic [CRC_W-1:0] XOROUT  = {CRC_W{1'b0}},
    parameter logic [CRC_W-1:0] RESIDUE = {CRC_W{1'b0}},
    parameter int unsigned      LEN_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    input  logic [DATA_W-1:0] i_s_data,
    input  logic              i_s_sop,
    input  logic              i_s_eop,
    output logic              o_m_valid,
    input  logic              i_m_ready,
    output logic [CRC_W-1:0]  o_m_crc,
    output logic              o_m_ok,
    output logic [LEN_W-1:0]  o_m_len,
    output logic              o_frame_abort
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // One beat through the LFSR: optional per-byte reflection, then all bits MSB-first.
    function automatic logic [CRC_W-1:0] f_crc_beat(input logic [CRC_W-1:0] lfsr_in,
                                                    input logic [DATA_W-1:0] data);
        logic [CRC_W-1:0]  l;
        logic [DATA_W-1:0] d;
        logic              fb;
        l = lfsr_in;
        d = data;
        if (REFIN) begin
            for (int b = 0; b < int'(DATA_W / 8); b++) begin
                for (int j = 0; j < 8; j++) begin
                    d[int'(DATA_W) - 8 - 8*b + j] = data[int'(DATA_W) - 1 - 8*b - j];
                end
            end
        end
        for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
            fb = l[CRC_W-1] ^ d[i];
            l  = (l << 1) ^ (fb ? POLY : {CRC_W{1'b0}});
        end
        return l;
    endfunction

    // Full-width bit reversal used for REFOUT.
    function automatic logic [CRC_W-1:0] f_rev(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < int'(CRC_W); i++) begin
            r[i] = v[int'(CRC_W) - 1 - i];
        end
        return r;
    endfunction

    logic [0:0]       r_state;
    logic [CRC_W-1:0] r_lfsr;
    logic [LEN_W-1:0] r_cnt;
    logic             r_m_valid;
    logic [CRC_W-1:0] r_m_crc;
    logic             r_m_ok;
    logic [LEN_W-1:0] r_m_len;
    logic             r_abort;

    logic             w_s_ready;
    logic             w_accept;
    logic             w_restart;
    logic             w_take;
    logic [CRC_W-1:0] w_lfsr_base;
    logic [CRC_W-1:0] w_lfsr_next;
    logic [LEN_W-1:0] w_cnt_base;
    logic [LEN_W-1:0] w_cnt_next;
    logic [CRC_W-1:0] w_crc_out;

    // Input stalls only while an unread result would otherwise be overwritten.
    assign w_s_ready   = !(r_m_valid && !i_m_ready);
    assign w_accept    = i_s_valid && w_s_ready;
    // A beat starts from INIT when it opens a frame (sop) or when no frame is open.
    assign w_restart   = i_s_sop || (r_state == ST_IDLE);
    // Beats without sop while idle are ignored entirely.
    assign w_take      = w_accept && (i_s_sop || (r_state == ST_BUSY));
    assign w_lfsr_base = w_restart ? INIT : r_lfsr;
    assign w_cnt_base  = w_restart ? {LEN_W{1'b0}} : r_cnt;
    assign w_lfsr_next = f_crc_beat(w_lfsr_base, i_s_data);
    assign w_cnt_next  = (&w_cnt_base) ? w_cnt_base : w_cnt_base + LEN_W'(1);
    assign w_crc_out   = (REFOUT ? f_rev(w_lfsr_next) : w_lfsr_next) ^ XOROUT;

    // Frame state, running LFSR/count and the held result register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_lfsr    <= INIT;
            r_cnt     <= '0;
            r_m_valid <= 1'b0;
            r_m_crc   <= '0;
            r_m_ok    <= 1'b0;
            r_m_len   <= '0;
            r_abort   <= 1'b0;
        end else if (i_clear) begin
            r_state   <= ST_IDLE;
            r_lfsr    <= INIT;
            r_cnt     <= '0;
            r_m_valid <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_abort <= w_accept && i_s_sop && (r_state == ST_BUSY);
            if (w_take && i_s_eop) begin
                // Frame closes: publish result, rearm for the next sop.
                r_state   <= ST_IDLE;
                r_lfsr    <= INIT;
                r_cnt     <= '0;
                r_m_valid <= 1'b1;
                r_m_crc   <= w_crc_out;
                r_m_ok    <= (w_lfsr_next == RESIDUE);
                r_m_len   <= w_cnt_next;
            end else begin
                if (w_take) begin
                    r_state <= ST_BUSY;
                    r_lfsr  <= w_lfsr_next;
                    r_cnt   <= w_cnt_next;
                end
                if (r_m_valid && i_m_ready) begin
                    r_m_valid <= 1'b0;
                end
            end
        end
    end

    assign o_s_ready     = w_s_ready;
    assign o_m_valid     = r_m_valid;
    assign o_m_crc       = r_m_crc;
    assign o_m_ok        = r_m_ok;
    assign o_m_len       = r_m_len;
    assign o_frame_abort = r_abort;

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb_crc_stream_engine: CRC-8 engine against a frame-level reference model plus a CRC-32/24-bit-beat instance.
// Latency: checks result one cycle after eop; compare process runs every falling edge.
// Backpressure: m_ready driven either directly or randomly; s_ready checked against the model every cycle.
module tb_crc_stream_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // CRC-8 instance (narrow length counter so saturation is reachable)
    logic        a_clear, a_s_valid, a_s_ready, a_s_sop, a_s_eop;
    logic [7:0]  a_s_data;
    logic        a_m_valid, a_m_ready, a_m_ok, a_abort;
    logic [7:0]  a_m_crc;
    logic [3:0]  a_m_len;
    logic        rand_rdy, rnd_rdy, ready_force;

    // CRC-32 instance, 24-bit beats, reflected
    logic        b_clear, b_s_valid, b_s_ready, b_s_sop, b_s_eop;
    logic [23:0] b_s_data;
    logic        b_m_valid, b_m_ready, b_m_ok, b_abort;
    logic [31:0] b_m_crc;
    logic [15:0] b_m_len;

    assign a_m_ready = rand_rdy ? rnd_rdy : ready_force;

    crc_stream_engine #(.LEN_W(4)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(a_clear),
        .i_s_valid(a_s_valid), .o_s_ready(a_s_ready), .i_s_data(a_s_data),
        .i_s_sop(a_s_sop), .i_s_eop(a_s_eop),
        .o_m_valid(a_m_valid), .i_m_ready(a_m_ready), .o_m_crc(a_m_crc),
        .o_m_ok(a_m_ok), .o_m_len(a_m_len), .o_frame_abort(a_abort)
    );

    crc_stream_engine #(
        .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .DATA_W(24),
        .REFIN(1'b1), .REFOUT(1'b1), .XOROUT(32'hFFFFFFFF), .RESIDUE(32'h0), .LEN_W(16)
    ) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(b_clear),
        .i_s_valid(b_s_valid), .o_s_ready(b_s_ready), .i_s_data(b_s_data),
        .i_s_sop(b_s_sop), .i_s_eop(b_s_eop),
        .o_m_valid(b_m_valid), .i_m_ready(b_m_ready), .o_m_crc(b_m_crc),
        .o_m_ok(b_m_ok), .o_m_len(b_m_len), .o_frame_abort(b_abort)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [63:0] rev_w(input logic [63:0] v, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = v[w-1-i];
        return r;
    endfunction

    // Textbook bitwise CRC over a whole frame's byte sequence.
    function automatic logic [63:0] crc_raw(input logic [7:0] q[$], input int w,
                                            input logic [63:0] poly, input logic [63:0] init,
                                            input bit refin);
        logic [63:0] mask, c;
        logic [7:0]  b;
        logic        fb;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        c = init & mask;
        foreach (q[k]) begin
            b = refin ? rev8(q[k]) : q[k];
            for (int i = 7; i >= 0; i--) begin
                fb = c[w-1] ^ b[i];
                c  = ((c << 1) ^ (fb ? poly : 64'd0)) & mask;
            end
        end
        return c;
    endfunction

    function automatic logic [63:0] crc_final(input logic [63:0] raw, input int w,
                                              input bit refout, input logic [63:0] xorout);
        return (refout ? rev_w(raw, w) : raw) ^ xorout;
    endfunction

    // ---------------- reference model + compare process for instance A ----------------
    logic [7:0] mq[$];
    int         mbeats = 0;
    bit         mopen = 0, ev = 0, eok = 0, eab = 0;
    logic [7:0] ecrc = '0;
    int         elen = 0;

    initial begin
        bit          acc, pop, load;
        logic [63:0] raw;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_m_valid", a_m_valid, 0);
                chk("rst_m_crc", a_m_crc, 0);
                chk("rst_m_ok", a_m_ok, 0);
                chk("rst_m_len", a_m_len, 0);
                chk("rst_abort", a_abort, 0);
                mq.delete(); mbeats = 0; mopen = 0; ev = 0; eok = 0; eab = 0; ecrc = '0; elen = 0;
            end else begin
                chk("m_valid", a_m_valid, ev);
                if (ev) begin
                    chk("m_crc", a_m_crc, ecrc);
                    chk("m_ok", a_m_ok, eok);
                    chk("m_len", a_m_len, elen);
                end
                chk("frame_abort", a_abort, eab);
                chk("s_ready", a_s_ready, !(ev && !a_m_ready));
                if (a_clear) begin
                    mq.delete(); mopen = 0; ev = 0; eab = 0;
                end else begin
                    acc  = a_s_valid && !(ev && !a_m_ready);
                    pop  = ev && a_m_ready;
                    eab  = acc && a_s_sop && mopen;
                    load = 0;
                    if (acc && (a_s_sop || mopen)) begin
                        if (a_s_sop) begin mq.delete(); mbeats = 0; end
                        mq.push_back(a_s_data);
                        mbeats++;
                        mopen = 1;
                        if (a_s_eop) begin
                            raw   = crc_raw(mq, 8, 64'h31, 64'hFF, 1'b0);
                            ecrc  = crc_final(raw, 8, 1'b0, 64'h0);
                            eok   = (raw[7:0] == 8'h00);
                            elen  = (mbeats > 15) ? 15 : mbeats;
                            load  = 1;
                            mopen = 0;
                        end
                    end
                    if (load) ev = 1;
                    else if (pop) ev = 0;
                end
            end
        end
    end

    // Random consumer readiness
    initial begin
        rnd_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            rnd_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    // Watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- drivers (inputs change #1 after rising edge) ----------------
    task automatic a_beat(input logic [7:0] d, input bit sop, input bit eop);
        int n = 0;
        bit rdy;
        a_s_valid = 1; a_s_data = d; a_s_sop = sop; a_s_eop = eop;
        do begin
            @(negedge clk); rdy = a_s_ready;
            @(posedge clk); #1; n++;
        end while (!rdy && n < 200);
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL a_beat_timeout actual=stalled required=accepted");
        end
        a_s_valid = 0; a_s_sop = 0; a_s_eop = 0;
    endtask

    task automatic a_frame(input logic [7:0] q[$]);
        foreach (q[i]) a_beat(q[i], i == 0, i == q.size() - 1);
    endtask

    task automatic a_wait_result(input string name, input logic [7:0] crc, input int len,
                                 input bit ok, output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!a_m_valid && lat < 100);
        chk({name, "_valid"}, a_m_valid, 1);
        chk({name, "_crc"}, a_m_crc, crc);
        chk({name, "_len"}, a_m_len, len);
        chk({name, "_ok"}, a_m_ok, ok);
        @(posedge clk); #1;
    endtask

    task automatic b_beat(input logic [23:0] d, input bit sop, input bit eop);
        int n = 0;
        bit rdy;
        b_s_valid = 1; b_s_data = d; b_s_sop = sop; b_s_eop = eop;
        do begin
            @(negedge clk); rdy = b_s_ready;
            @(posedge clk); #1; n++;
        end while (!rdy && n < 200);
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL b_beat_timeout actual=stalled required=accepted");
        end
        b_s_valid = 0; b_s_sop = 0; b_s_eop = 0;
    endtask

    task automatic b_wait_result(input string name, input logic [31:0] crc, input int len, input bit ok);
        int n = 0;
        do begin @(negedge clk); n++; end while (!b_m_valid && n < 100);
        chk({name, "_valid"}, b_m_valid, 1);
        chk({name, "_latency"}, n, 1);
        chk({name, "_crc"}, b_m_crc, crc);
        chk({name, "_len"}, b_m_len, len);
        chk({name, "_ok"}, b_m_ok, ok);
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0]  t1[$];
        logic [7:0]  q[$];
        logic [23:0] bw[$];
        logic [63:0] raw;
        int          lat, len, gap, r;
        bit          trunc;

        rst_n = 0;
        a_clear = 0; a_s_valid = 0; a_s_data = '0; a_s_sop = 0; a_s_eop = 0;
        b_clear = 0; b_s_valid = 0; b_s_data = '0; b_s_sop = 0; b_s_eop = 0;
        b_m_ready = 1; rand_rdy = 0; ready_force = 1;

        t1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        // Model pinned to known check values
        chk("model_crc8", crc_raw(t1, 8, 64'h31, 64'hFF, 1'b0), 64'hF7);
        chk("model_crc32", crc_final(crc_raw(t1, 32, 64'h04C11DB7, 64'hFFFFFFFF, 1'b1), 32, 1'b1, 64'hFFFFFFFF),
            64'hCBF43926);

        @(negedge clk);
        chk("b_rst_m_valid", b_m_valid, 0);
        chk("b_rst_m_crc", b_m_crc, 0);
        chk("b_rst_m_len", b_m_len, 0);
        chk("b_rst_abort", b_abort, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // T1: "123456789" -> 0xF7, latency 1
        a_frame(t1);
        a_wait_result("t1", 8'hF7, 9, 1'b0, lat);
        chk("t1_latency", lat, 1);

        // T2: frame + its CRC -> zero residue
        q = t1; q.push_back(8'hF7);
        a_frame(q);
        a_wait_result("t2", 8'h00, 10, 1'b1, lat);

        // T3: result held while m_ready low, next frame stalls
        ready_force = 0;
        a_frame(t1);
        fork
            a_frame(t1);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("t3_hold_valid", a_m_valid, 1);
                    chk("t3_hold_crc", a_m_crc, 8'hF7);
                    chk("t3_s_ready", a_s_ready, 0);
                end
                @(posedge clk); #1;
                ready_force = 1;
            end
        join
        a_wait_result("t3_next", 8'hF7, 9, 1'b0, lat);

        // Length saturation at 15 (4-bit counter)
        q.delete();
        for (int i = 0; i < 17; i++) q.push_back(8'(i * 7));
        raw = crc_raw(q, 8, 64'h31, 64'hFF, 1'b0);
        a_frame(q);
        a_wait_result("sat", raw[7:0], 15, raw[7:0] == 8'h00, lat);

        // T5: open frame abandoned by new sop
        for (int i = 0; i < 4; i++) a_beat(8'($urandom), i == 0, 1'b0);
        a_beat(8'h31, 1'b1, 1'b0);
        @(negedge clk);
        chk("t5_abort_pulse", a_abort, 1);
        @(negedge clk);
        chk("t5_abort_clear", a_abort, 0);
        @(posedge clk); #1;
        for (int i = 1; i < 9; i++) a_beat(t1[i], 1'b0, i == 8);
        a_wait_result("t5", 8'hF7, 9, 1'b0, lat);

        // T6: clear mid-frame drops the frame and the beat presented with it
        a_beat(8'h31, 1'b1, 1'b0);
        a_beat(8'h32, 1'b0, 1'b0);
        a_clear = 1;
        a_beat(8'h33, 1'b0, 1'b0);
        a_clear = 0;
        for (int i = 3; i < 9; i++) a_beat(t1[i], 1'b0, i == 8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_result", a_m_valid, 0);
        end
        @(posedge clk); #1;

        // Reset while a result is pending
        ready_force = 0;
        a_frame(t1);
        #3 rst_n = 0;
        #1;
        chk("t6_rst_pending_valid", a_m_valid, 0);
        chk("t6_rst_pending_crc", a_m_crc, 0);
        ready_force = 1;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // Reset mid-frame; stray beats afterwards must not close anything
        a_beat(8'h31, 1'b1, 1'b0);
        a_beat(8'h32, 1'b0, 1'b0);
        #3 rst_n = 0;
        #1;
        chk("t6_rst_mid_valid", a_m_valid, 0);
        chk("t6_rst_mid_len", a_m_len, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        a_beat(8'h33, 1'b0, 1'b0);
        a_beat(8'h34, 1'b0, 1'b1);
        a_frame(t1);
        a_wait_result("t6_after", 8'hF7, 9, 1'b0, lat);

        // Randomized traffic, checked cycle by cycle by the compare process
        rand_rdy = 1;
        for (int f = 0; f < 150; f++) begin
            r = $urandom_range(0, 15);
            if (r == 0) a_beat(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
            if (r == 1) begin
                a_clear = 1;
                a_beat(8'($urandom), 1'b1, 1'b1);
                a_clear = 0;
            end
            len = $urandom_range(1, 20);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            if (r == 2) begin
                raw = crc_raw(q, 8, 64'h31, 64'hFF, 1'b0);
                q.push_back(raw[7:0]);
            end
            trunc = (r == 3);
            foreach (q[i]) begin
                if (trunc && i == q.size() - 1) break;
                a_beat(q[i], i == 0, i == q.size() - 1);
                gap = $urandom_range(0, 2);
                if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
            end
        end
        rand_rdy = 0;
        ready_force = 1;
        repeat (4) @(posedge clk); #1;

        // T4: CRC-32 over 24-bit beats
        b_beat(24'h313233, 1'b1, 1'b0);
        b_beat(24'h343536, 1'b0, 1'b0);
        b_beat(24'h373839, 1'b0, 1'b1);
        b_wait_result("t4", 32'hCBF43926, 3, 1'b0);

        for (int f = 0; f < 10; f++) begin
            len = $urandom_range(1, 5);
            bw.delete(); q.delete();
            for (int i = 0; i < len; i++) begin
                bw.push_back(24'($urandom));
                q.push_back(bw[i][23:16]); q.push_back(bw[i][15:8]); q.push_back(bw[i][7:0]);
            end
            raw = crc_raw(q, 32, 64'h04C11DB7, 64'hFFFFFFFF, 1'b1);
            foreach (bw[i]) b_beat(bw[i], i == 0, i == len - 1);
            b_wait_result("b_rand", 32'(crc_final(raw, 32, 1'b1, 64'hFFFFFFFF)), len, raw[31:0] == 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
